// File: rtl/cache_pkg.sv
// Shared definitions for the 2 KB two-way cache and its miss-fill controller.
// Holds the fill state encoding, line geometry and block/word address helpers.
package cache_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_BYTES = 16;
  localparam int OFFSET_BITS = 4;
  localparam int WORD_BITS   = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WRITE_TAG = 2'd2
  } fill_state_t;

  // Byte address of the first byte of the line containing addr.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  // Byte address of 16-bit word idx inside the line starting at base.
  // base is line aligned, so the add never carries out of the offset bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]    base,
                                                  input logic [WORD_BITS-1:0] idx);
    return base + {{(ADDR_W-WORD_BITS-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/block_word_counter.sv
// Word index counter for one side of a line fill (request issue or data receive).
// done latches once the counter wraps past the last word and holds until cleared.
module block_word_counter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [WORD_BITS-1:0] count,
  output logic                 done
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation/synthesis mismatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (inc) begin
      count <= count + 1'b1;
      if (count == '1) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches a 16-byte line word by word from memory, writes
// each word into the cache data array, then writes the tag/valid metadata last.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MissDetected,
  input  logic [ADDR_W-1:0] MissAddress,
  input  logic [DATA_W-1:0] MemDataIn,
  input  logic              MemDataValid,
  output logic              MemEnable,
  output logic [ADDR_W-1:0] MemAddress,
  output logic              FsmBusy,
  output logic [ADDR_W-1:0] CacheAddress,
  output logic [DATA_W-1:0] CacheData,
  output logic              WriteDataArray,
  output logic              WriteTagArray
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be in 1..8");
  end
  if (WORDS_PER_BLOCK != (1 << WORD_BITS) || BLOCK_BYTES != 2 * WORDS_PER_BLOCK) begin : g_bad_geometry
    $error("cache_fill_fsm: line geometry must be 8 words of 16 bits");
  end

  fill_state_t          state_q;
  fill_state_t          state_d;
  logic [ADDR_W-1:0]    base_q;
  logic                 start;
  logic                 issue_fire;
  logic                 recv_fire;
  logic [WORD_BITS-1:0] ic_count;
  logic                 ic_done;
  logic [WORD_BITS-1:0] rc_count;
  logic                 rc_done;

  assign start      = (state_q == IDLE) && MissDetected;
  assign issue_fire = (state_q == FETCH) && !ic_done;
  // rc_done guards against any response beyond the eighth word of this line.
  assign recv_fire  = (state_q == FETCH) && MemDataValid && !rc_done;

  block_word_counter u_issue_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .inc   (issue_fire),
    .count (ic_count),
    .done  (ic_done)
  );

  block_word_counter u_recv_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .inc   (recv_fire),
    .count (rc_count),
    .done  (rc_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q <= block_base(MissAddress);
      end
    end
  end

  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (MissDetected) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (recv_fire && rc_count == WORD_BITS'(WORDS_PER_BLOCK - 1)) begin
          state_d = WRITE_TAG;
        end
      end
      WRITE_TAG: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request and return sides are decoded independently so they can overlap.
  always_comb begin
    MemEnable      = 1'b0;
    MemAddress     = '0;
    FsmBusy        = (state_q != IDLE);
    CacheAddress   = '0;
    CacheData      = '0;
    WriteDataArray = 1'b0;
    WriteTagArray  = 1'b0;

    if (issue_fire) begin
      MemEnable  = 1'b1;
      MemAddress = word_addr(base_q, ic_count);
    end

    if (recv_fire) begin
      WriteDataArray = 1'b1;
      CacheAddress   = word_addr(base_q, rc_count);
      CacheData      = MemDataIn;
    end else if (state_q == WRITE_TAG) begin
      WriteTagArray = 1'b1;
      CacheAddress  = base_q;
    end
  end

  // Metadata must never be written alongside a data word, and requests only
  // leave while a fill is fetching.
  a_tag_alone: assert property (@(posedge clk) disable iff (rst)
    WriteTagArray |-> !WriteDataArray);
  a_req_in_fetch: assert property (@(posedge clk) disable iff (rst)
    MemEnable |-> (state_q == FETCH));

endmodule
